// File: rtl/wfr_sample_packer.sv
// wfr_sample_packer: decimates signed samples by 2^decimLog2 and packs DATA_WIDTH/SAMPLE_WIDTH kept samples per output word
// Optional WFR_PACKER_AVERAGE_EN: each kept value is the boxcar mean of its group instead of its first sample.
module wfr_sample_packer #(
    parameter int SAMPLE_WIDTH    = 32,
    parameter int DATA_WIDTH      = 128,
    parameter int TIMESTAMP_WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [3:0]                 decimLog2,
    input  logic [SAMPLE_WIDTH-1:0]    sampleIn,
    input  logic                       sampleValid,
    input  logic [7:0]                 triggerIn,
    input  logic [TIMESTAMP_WIDTH-1:0] timestampIn,
    output logic [DATA_WIDTH-1:0]      data,
    output logic                       valid,
    output logic [7:0]                 triggers,
    output logic [TIMESTAMP_WIDTH-1:0] timestamp
);
    localparam int LANES = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int LW    = $clog2(LANES);

    generate
        if (DATA_WIDTH % SAMPLE_WIDTH != 0 || LANES < 2) begin : g_bad_cfg
            $error("DATA_WIDTH must be a multiple of SAMPLE_WIDTH with at least two lanes");
        end
    endgenerate

    logic                       en_q;
    logic [3:0]                 decim_reg;
    logic [14:0]                grp_cnt;
    logic [LW-1:0]              lane;
    logic [7:0]                 pending;
    logic [TIMESTAMP_WIDTH-1:0] ts_hold;
    logic [DATA_WIDTH-SAMPLE_WIDTH-1:0] lanes_q;
    logic [3:0]                 decim;
    logic [14:0]                last_cnt;
    logic                       accept;
    logic                       first;
    logic                       group_done;
    logic                       emit;
    logic [SAMPLE_WIDTH-1:0]    kept;
`ifdef WFR_PACKER_AVERAGE_EN
    logic signed [SAMPLE_WIDTH+14:0] acc_q;
    logic signed [SAMPLE_WIDTH+14:0] sum;
`else
    logic [SAMPLE_WIDTH-1:0]    first_q;
`endif

    // Accept/complete/emit decisions; on the enable rising edge the live decimLog2 already applies
    always_comb begin
        decim      = (enable && !en_q) ? decimLog2 : decim_reg;
        last_cnt   = 15'((16'd1 << decim) - 16'd1);
        accept     = enable && sampleValid;
        first      = grp_cnt == 15'd0;
        group_done = accept && grp_cnt == last_cnt;
        emit       = group_done && lane == LW'(LANES - 1);
`ifdef WFR_PACKER_AVERAGE_EN
        sum        = first ? {{15{sampleIn[SAMPLE_WIDTH-1]}}, sampleIn}
                           : acc_q + {{15{sampleIn[SAMPLE_WIDTH-1]}}, sampleIn};
        kept       = SAMPLE_WIDTH'(sum >>> decim);
`else
        kept       = first ? sampleIn : first_q;
`endif
    end

    // Group/lane counting, lane storage, trigger accumulation and registered word output
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            decim_reg <= '0;
            grp_cnt   <= '0;
            lane      <= '0;
            pending   <= '0;
            ts_hold   <= '0;
            lanes_q   <= '0;
`ifdef WFR_PACKER_AVERAGE_EN
            acc_q     <= '0;
`else
            first_q   <= '0;
`endif
            data      <= '0;
            valid     <= 1'b0;
            triggers  <= '0;
            timestamp <= '0;
        end else begin
            en_q  <= enable;
            valid <= emit;
            if (enable && !en_q) decim_reg <= decimLog2;
            if (!enable) begin
                grp_cnt <= '0;
                lane    <= '0;
                pending <= '0;
            end else begin
                pending <= emit ? 8'd0 : pending | triggerIn;
                if (accept) begin
                    grp_cnt <= group_done ? 15'd0 : grp_cnt + 15'd1;
                    if (group_done) lane <= emit ? '0 : lane + 1'b1;
`ifdef WFR_PACKER_AVERAGE_EN
                    acc_q <= sum;
`else
                    if (first) first_q <= sampleIn;
`endif
                    if (first && lane == '0) ts_hold <= timestampIn;
                    if (group_done && !emit) lanes_q[lane*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= kept;
                end
            end
            if (emit) begin
                data      <= {kept, lanes_q};
                triggers  <= pending | triggerIn;
                timestamp <= ts_hold;
            end
        end
    end
endmodule

// File: doc/wfr_sample_packer.md
# wfr_sample_packer

Upstream feeder for the generic waveform recorder, in the `clk` domain. Takes one `SAMPLE_WIDTH`-bit sample per `sampleValid` cycle. Decimates by a power of two, packs `LANES = DATA_WIDTH/SAMPLE_WIDTH` kept samples into one `DATA_WIDTH` word, and presents it on the recorder's `data`/`valid`/`triggers`/`timestamp` inputs. There is no backpressure, which matches the recorder's valid-only input.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 32: width of one input sample (signed two's complement).
- `DATA_WIDTH`, 128: packed output width; must be an integer multiple of `SAMPLE_WIDTH`, with `LANES` ≥ 2. Violations are elaborate-time errors.
- `TIMESTAMP_WIDTH`, 64: timestamp width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: packing enable (already in the `clk` domain).
- `decimLog2` in 4: decimation exponent; group size `G = 2^decimLog2`, range 1..32768.
- `sampleIn` in `SAMPLE_WIDTH`: input sample.
- `sampleValid` in 1: `sampleIn` is valid this cycle.
- `triggerIn` in 8: raw trigger levels or pulses.
- `timestampIn` in `TIMESTAMP_WIDTH`: free-running timestamp.
- `data` out `DATA_WIDTH`: packed word; lane 0 is in the LSBs and is the oldest sample.
- `valid` out 1: one-cycle pulse per packed word.
- `triggers` out 8: trigger bits seen during the emitted word, held until the next emit.
- `timestamp` out `TIMESTAMP_WIDTH`: timestamp of the word's first accepted sample.

## Operation
- Counters:
  - `grpCnt` (15 bit) counts samples within a group.
  - `lane` (`log2(LANES)` bit) selects the lane.
- `decimLog2` is captured into `decimReg` on the `enable` 0→1 edge. Changes while enabled are ignored.
- Accept rule: a sample is accepted when `enable` && `sampleValid`.
  - If `grpCnt == G-1`: the group completes, the kept value goes to lane `lane`, `grpCnt` is set to 0 and `lane` increments (modulo `LANES`).
  - Otherwise `grpCnt` increments.
- Kept value without the macro: the first sample of the group (`grpCnt == 0`).
- Timestamp: the `timestampIn` present on the accept with `lane == 0` && `grpCnt == 0` is held as `tsHold`.
- Emit: a group completes with `lane == LANES-1`.
  - Next cycle: `valid = 1`, `data` = all lanes, `timestamp = tsHold`.
  - The next word starts filling immediately; no samples are lost.
- Triggers:
  - `pending |= triggerIn` every cycle while enabled.
  - On the emit cycle, `triggers <= pending | triggerIn` and `pending <= 0`.
  - A trigger arriving on the emit cycle belongs to the word being emitted.
- `enable` low:
  - `grpCnt`, `lane` and `pending` are cleared and any partial word is discarded.
  - `valid` stays 0; `data`, `triggers` and `timestamp` hold.
  - If `enable` falls on the emit cycle, the pending word is still presented next cycle.
- `rst` overrides everything:
  - Outputs: `data = 0`, `valid = 0`, `triggers = 0`, `timestamp = 0`.
  - Internal state: `grpCnt = 0`, `lane = 0`, `pending = 0`, `decimReg = 0`, `tsHold = 0`.
  - Reset mid-word discards the partial word.
  - If `enable` is high when `rst` deasserts, the 0→1 edge is taken as occurring on the first cycle after reset, so `decimLog2` is captured then.

## Timing
- Latency: the accept cycle of the word's last sample is N; `valid` is high on N+1 for exactly one cycle.
- Minimum spacing between `valid` pulses is `LANES·G` accepts. With `sampleValid` high continuously and `G = 1`, spacing is `LANES` cycles.
- `triggers` is registered and changes only on emit cycles (or reset), so downstream edge detection sees at most one rising edge per word.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- Macro `WFR_PACKER_AVERAGE_EN`.
  - Defined: each kept value is the boxcar mean of the group.
    - The signed accumulator is `SAMPLE_WIDTH+15` bits wide. It is loaded with the first sample and adds each subsequent sample.
    - On group completion the lane value is `(acc + sample) >>> decimReg`, truncated to `SAMPLE_WIDTH` bits.
    - Latency is unchanged.
  - Undefined: no accumulator is instantiated; behaviour is plain first-sample decimation as described in Operation.

## Test plan
- Reset/idle: assert `rst` mid-word, release with `enable = 0` → all outputs 0, no `valid` while `sampleValid` toggles.
- Pack, no decimation: `decimLog2 = 0`, continuous samples 1,2,3,4,5… → `valid` on the cycle after sample 4 with `data = {4,3,2,1}`, then after sample 8 with `data = {8,7,6,5}`. `timestamp` equals the `timestampIn` of sample 1.
- Decimation: `decimLog2 = 2`, samples 0..15 → one word `{12,8,4,0}`. With `WFR_PACKER_AVERAGE_EN`: `{13,9,5,1}` (means 1.5, 5.5, 9.5, 13.5 floored).
- Gapped valid: `sampleValid` high every third cycle, `decimLog2 = 0` → word contents identical to the contiguous case; `valid` one cycle after the 4th accept.
- Triggers: pulse `triggerIn = 8'h01` mid-word, and `8'h80` on the emit cycle → `triggers = 8'h81` with that word, then `8'h00` at the next emit.
- Enable/decim change: change `decimLog2` while enabled → ignored. Drop `enable` after 2 samples, re-enable → the partial word is discarded and the new word starts at lane 0 with the new `decimLog2`.
